// File: rtl/delta_decoder_8bit_if.sv
// Stream bundle for the delta decoder: upstream running sums in, recovered differences out.
interface delta_decoder_8bit_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] i_s;
    logic             i_valid;
    logic             o_ready;
    logic [WIDTH-1:0] o_d;
    logic             o_borrow;
    logic             o_ovf;
    logic             o_valid;
    logic             i_ready;

    modport master (
        output i_s, i_valid, i_ready,
        input  o_ready, o_d, o_borrow, o_ovf, o_valid
    );

    modport slave (
        input  i_s, i_valid, i_ready,
        output o_ready, o_d, o_borrow, o_ovf, o_valid
    );
endinterface

// File: rtl/delta_decoder_8bit.sv
// Recovers per-sample addends d[n] = s[n] - s[n-1] from an accumulator's running-sum stream.
// Optional DELTA_DECODER_SEED_EN: first sample after reset/clear only seeds history.
//   state | meaning
//   SEED  | no history yet; next accepted sample only loads prev
//   RUN   | history valid; every accepted sample yields a difference
module delta_decoder_8bit #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             ni_rst,
    input  logic             i_clr,
    delta_decoder_8bit_if.slave bus,
    output logic [CNT_W-1:0] o_count
);
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] d_q;
    logic [WIDTH-1:0] diff;
    logic             borrow_q;
    logic             ovf_q;
    logic             valid_q;
    logic [CNT_W-1:0] count_q;
    logic             borrow_n;
    logic             ovf_n;
    logic             acc;
    logic             seeding;

    // i_ready feeds o_ready combinationally so a drained slot refills in the same cycle
    assign bus.o_ready = (~valid_q | bus.i_ready) & ~i_clr;
    assign acc         = bus.i_valid & bus.o_ready;

`ifdef DELTA_DECODER_SEED_EN
    typedef enum logic {
        SEED = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t state_q;
    state_t state_n;

    always_ff @(posedge i_clk or negedge ni_rst) begin
        if (!ni_rst) begin
            state_q <= SEED;
        end else begin
            state_q <= state_n;
        end
    end

    always_comb begin
        state_n = state_q;
        if (i_clr) begin
            state_n = SEED;
        end else if ((state_q == SEED) && acc) begin
            state_n = RUN;
        end
    end

    assign seeding = (state_q == SEED);
`else
    assign seeding = 1'b0;
`endif

    always_comb begin
        diff     = bus.i_s - prev_q;
        borrow_n = (bus.i_s < prev_q);
        // operands of differing sign whose result sign disagrees with the minuend
        ovf_n    = (bus.i_s[WIDTH-1] != prev_q[WIDTH-1]) && (diff[WIDTH-1] != bus.i_s[WIDTH-1]);
    end

    always_ff @(posedge i_clk or negedge ni_rst) begin
        if (!ni_rst) begin
            prev_q   <= '0;
            d_q      <= '0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
            valid_q  <= 1'b0;
            count_q  <= '0;
        end else if (i_clr) begin
            prev_q   <= '0;
            d_q      <= '0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
            valid_q  <= 1'b0;
            count_q  <= '0;
        end else if (acc) begin
            prev_q <= bus.i_s;
            if (!seeding) begin
                d_q      <= diff;
                borrow_q <= borrow_n;
                ovf_q    <= ovf_n;
                valid_q  <= 1'b1;
                if (count_q != '1) begin
                    count_q <= count_q + 1'b1;
                end
            end else begin
                valid_q <= 1'b0;
            end
        end else if (valid_q & bus.i_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign bus.o_d      = d_q;
    assign bus.o_borrow = borrow_q;
    assign bus.o_ovf    = ovf_q;
    assign bus.o_valid  = valid_q;
    assign o_count      = count_q;
endmodule

// File: tb/tb_delta_decoder_8bit.sv
// Directed plus randomized bench for delta_decoder_8bit with an arithmetic reference model.
module tb_delta_decoder_8bit;
`ifdef DELTA_DECODER_SEED_EN
    localparam bit SEED_ON = 1'b1;
`else
    localparam bit SEED_ON = 1'b0;
`endif

    logic       i_clk = 1'b0;
    logic       ni_rst;
    logic       i_clr;
    logic [7:0] o_count;

    delta_decoder_8bit_if #(.WIDTH(8)) bus ();

    delta_decoder_8bit #(.WIDTH(8), .CNT_W(8)) dut (
        .i_clk   (i_clk),
        .ni_rst  (ni_rst),
        .i_clr   (i_clr),
        .bus     (bus),
        .o_count (o_count)
    );

    always #5 i_clk = ~i_clk;

    int n_pass  = 0;
    int n_total = 0;

    int m_prev, m_d, m_count;
    bit m_borrow, m_ovf, m_valid, m_seeded;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_prev = 0; m_d = 0; m_count = 0;
        m_borrow = 0; m_ovf = 0; m_valid = 0; m_seeded = 0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "_valid"},  {31'd0, bus.o_valid},  {31'd0, m_valid});
        chk({tag, "_d"},      {24'd0, bus.o_d},      m_d);
        chk({tag, "_borrow"}, {31'd0, bus.o_borrow}, {31'd0, m_borrow});
        chk({tag, "_ovf"},    {31'd0, bus.o_ovf},    {31'd0, m_ovf});
        chk({tag, "_count"},  {24'd0, o_count},      m_count);
    endtask

    // Called at a falling edge; applies inputs, checks o_ready, advances one clock, checks outputs.
    task automatic cycle(input string tag, input bit v, input int s, input bit r, input bit c);
        bit exp_ready, acc;
        int ss, sp, t;
        bus.i_valid = v; bus.i_s = s[7:0]; bus.i_ready = r; i_clr = c;
        #1;
        exp_ready = (!m_valid || r) && !c;
        chk({tag, "_ready"}, {31'd0, bus.o_ready}, {31'd0, exp_ready});
        acc = v && exp_ready;
        if (c) begin
            model_reset();
        end else if (acc) begin
            if (SEED_ON && !m_seeded) begin
                m_prev = s; m_seeded = 1; m_valid = 0;
            end else begin
                m_seeded = 1;
                m_d      = (s - m_prev + 256) % 256;
                m_borrow = (s < m_prev);
                ss = (s >= 128) ? s - 256 : s;
                sp = (m_prev >= 128) ? m_prev - 256 : m_prev;
                t  = ss - sp;
                m_ovf   = (t > 127) || (t < -128);
                m_valid = 1;
                m_prev  = s;
                if (m_count < 255) m_count++;
            end
        end else if (m_valid && r) begin
            m_valid = 0;
        end
        @(posedge i_clk);
        @(negedge i_clk);
        check_outputs(tag);
    endtask

    task automatic do_reset(input string tag);
        ni_rst = 1'b0;
        #1;
        model_reset();
        check_outputs(tag);
        @(negedge i_clk);
        ni_rst = 1'b1;
    endtask

    initial begin
        bus.i_valid = 1'b0; bus.i_s = 8'h00; bus.i_ready = 1'b0; i_clr = 1'b0;
        model_reset();
        do_reset("rst0");

        // basic stream
        cycle("t1a", 1, 8'h05, 1, 0);
        cycle("t1b", 1, 8'h0A, 1, 0);
        cycle("t1c", 1, 8'h0F, 1, 0);
`ifndef DELTA_DECODER_SEED_EN
        chk("t1_d_const", {24'd0, bus.o_d}, 32'h05);
        chk("t1_count_const", {24'd0, o_count}, 32'd3);
`endif
        cycle("t1idle", 0, 8'h00, 1, 0);

        // wrap and signed overflow
        cycle("t2a", 1, 8'hF0, 1, 0);
        cycle("t2b", 1, 8'h10, 1, 0);
        chk("t2_wrap_d", {24'd0, bus.o_d}, 32'h20);
        chk("t2_wrap_borrow", {31'd0, bus.o_borrow}, 32'd1);
        chk("t2_wrap_ovf", {31'd0, bus.o_ovf}, 32'd0);
        cycle("t2c", 1, 8'h80, 1, 0);
        cycle("t2d", 1, 8'h7F, 1, 0);
        chk("t2_ovf_d", {24'd0, bus.o_d}, 32'hFF);
        chk("t2_ovf_borrow", {31'd0, bus.o_borrow}, 32'd1);
        chk("t2_ovf_ovf", {31'd0, bus.o_ovf}, 32'd1);

        // backpressure: three stalled cycles with continuous valid
        cycle("t3a", 1, 8'h90, 1, 0);
        for (int i = 0; i < 3; i++) begin
            cycle("t3stall", 1, 8'hA0, 0, 0);
            chk("t3_held_d", {24'd0, bus.o_d}, 32'h11);
        end
        cycle("t3b", 1, 8'hA0, 1, 0);
        chk("t3_after_d", {24'd0, bus.o_d}, 32'h10);
        cycle("t3c", 1, 8'hB5, 1, 0);
        chk("t3_next_d", {24'd0, bus.o_d}, 32'h15);

        // clear with valid input and pending output
        cycle("t4clr", 1, 8'h55, 1, 1);
        cycle("t4a", 1, 8'h09, 1, 0);
`ifndef DELTA_DECODER_SEED_EN
        chk("t4_prev_zero_d", {24'd0, bus.o_d}, 32'h09);
`else
        chk("t4_seed_novalid", {31'd0, bus.o_valid}, 32'd0);
        cycle("t4s0", 1, 8'h10, 1, 1);
        cycle("t4s1", 1, 8'h10, 1, 0);
        cycle("t4s2", 1, 8'h13, 1, 0);
        chk("t4_seed_d1", {24'd0, bus.o_d}, 32'h03);
        cycle("t4s3", 1, 8'h20, 1, 0);
        chk("t4_seed_d2", {24'd0, bus.o_d}, 32'h0D);
        chk("t4_seed_count", {24'd0, o_count}, 32'd2);
`endif

        // async reset mid-stall
        cycle("t5a", 1, 8'h40, 1, 0);
        cycle("t5stall", 1, 8'h41, 0, 0);
        do_reset("t5rst");
        cycle("t5b", 1, 8'h07, 1, 0);
`ifndef DELTA_DECODER_SEED_EN
        chk("t5_after_rst_d", {24'd0, bus.o_d}, 32'h07);
`endif

        // randomized traffic
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset("rndrst");
            end else begin
                cycle("rnd", 1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 255)),
                      1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 39) == 0));
            end
        end

        // counter saturation
        cycle("t7clr", 0, 0, 1, 1);
        for (int i = 0; i < 270; i++) begin
            cycle("t7sat", 1, int'($urandom_range(0, 255)), 1, 0);
        end
        chk("t7_sat_count", {24'd0, o_count}, 32'd255);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
